snax_tcdm_responder: RTL and testbench
======================================

# snax_tcdm_responder

Single-bank TCDM responder: the memory end of the SNAX accelerator TCDM ports. It accepts `tcdm_req_t` requests from `SnaxTcdmPorts` initiator ports, grants one port per cycle by rotating token, performs byte-strobed writes or 1-cycle-latency reads on an internal word array, and returns `tcdm_rsp_t` responses. It is the standalone memory model behind `snax_cgra_wrapper` in block-level benches and a small scratchpad in cluster builds.

## Interface
Parameters:
- `SnaxTcdmPorts`, 4: number of request/response port pairs.
- `DataWidth`, 64: word width; strobe width is `DataWidth/8`.
- `TCDMAddrWidth`, 48: width of `q.addr`.
- `Depth`, 64: words in the array; power of two, ≥ 2.
- `AddrLsb`, 0: bit position of the word index LSB within `q.addr`.
- `tcdm_req_t`, `tcdm_rsp_t`, logic: request/response structs (`q.write/addr/amo/data/strb/user`, `q_valid`; `q_ready`, `p_valid`, `p.data`).

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `tcdm_req_i` in `tcdm_req_t [SnaxTcdmPorts-1:0]`: requests.
- `tcdm_rsp_o` out `tcdm_rsp_t [SnaxTcdmPorts-1:0]`: responses.
- `stall_cnt_o` out 32: saturating count of denied requests.

## Operation
- Token: one-hot register `tok`, reset to port 0, advances one port per cycle (port N-1 wraps to 0) regardless of traffic.
- `q_ready[i] = tok[i]`. `q_ready` depends only on registered state; no combinational path from any `q_valid` to any `q_ready`. This is mandatory: initiators gate `q_valid` with `q_ready`.
- Handshake on port i: `q_valid[i] & q_ready[i]`. At most one per cycle.
- Word index = `q.addr[AddrLsb+$clog2(Depth)-1 : AddrLsb]`. Higher address bits are ignored, so out-of-range addresses alias/wrap.
- Write (`q.write=1`): for each byte b with `strb[b]=1`, `mem[idx][8b+7:8b] <= data[8b+7:8b]` at the handshake edge. No response is returned.
- Read (`q.write=0`): `mem[idx]` is captured into the response register. `p_valid[i]=1` with `p.data` in the following cycle only.
- Responses have no backpressure. `p_valid` is a single-cycle pulse. `p.data` is 0 whenever `p_valid=0`.
- `q.amo` other than `AMONone` is treated as a plain read/write. `q.user` is ignored.
- `stall_cnt_o` increments when any port has `q_valid=1` with `q_ready=0`, by 1 per cycle (not per port). It saturates at `32'hFFFF_FFFF`.

## Timing
- Reset values: `tok=0001`, all `q_ready` = token (port 0 high), all `p_valid=0`, `p.data=0`, `stall_cnt_o=0`, all array words 0.
- Read latency: request handshake in cycle t gives `p_valid`/`p.data` in cycle t+1.
- Write visibility: a write handshaked in cycle t is visible to a read handshaked in t+1 or later. Same-cycle conflict is impossible (single grant).
- Per-port grant period = `SnaxTcdmPorts` cycles. Aggregate throughput is ≤ 1 access/cycle.
- Reset mid-operation: a pending read response is dropped (no `p_valid` after reset release), the token returns to port 0, the array is zeroed, and the counter is cleared.
- First cycle after `rst_ni` rises: port 0 holds the token.

## Structure
- `snax_tcdm_pkg`: `amo_op_e` (incl. `AMONone`), response-register struct (port index, valid, data). The request/response types stay parameters.
- Sub-module `snax_tcdm_rr_token`: the rotating one-hot token register (param `N`, ports `clk_i`, `rst_ni`, `tok_o`).
- Top holds the array, grant mux, strobe write, response register, and stall counter.

## Test plan
- Reset then idle: `q_ready` = 0001, 0010, 0100, 1000, 0001 over 5 cycles. `p_valid` is never high. `stall_cnt_o=0`.
- Port 0 writes `64'h1122_3344_5566_7788` to idx 5 with strb `FF`, then port 1 reads idx 5 at its slot → port 1 `p_valid` one cycle later with that data, other ports `p_valid=0`.
- Partial strobe: write `64'hFFFF_FFFF_FFFF_FFFF` strb `8'h0F` to a zeroed word, read back → `64'h0000_0000_FFFF_FFFF`.
- Address wrap (`Depth=64`, `AddrLsb=0`): write `64'hA5` to addr 70, read addr 6 → `64'hA5`.
- All 4 ports hold `q_valid=1` for 8 cycles → exactly 8 handshakes, 2 per port in token order, `stall_cnt_o=8`.
- Read handshaked, `rst_ni` pulsed low before the next edge → no `p_valid`, `q_ready=0001` after release, prior data reads back 0.

Source files
------------

// File: rtl/snax_tcdm_pkg.sv
// Shared types for the SNAX TCDM responder.
// - amo_op_e: atomic opcode field carried in requests (the responder treats every
//   opcode as a plain read/write).
// - tcdm_req_default_t / tcdm_rsp_default_t: default request/response structs
//   (48-bit address, 64-bit data) used when the top is not given its own types.
package snax_tcdm_pkg;

   localparam int unsigned DefAddrWidth = 48;
   localparam int unsigned DefDataWidth = 64;

   typedef enum logic [3:0] {
      AMONone = 4'h0,
      AMOSwap = 4'h1,
      AMOAdd  = 4'h2,
      AMOAnd  = 4'h3,
      AMOOr   = 4'h4,
      AMOXor  = 4'h5,
      AMOMax  = 4'h6,
      AMOMaxu = 4'h7,
      AMOMin  = 4'h8,
      AMOMinu = 4'h9,
      AMOLR   = 4'hA,
      AMOSC   = 4'hB
   } amo_op_e;

   typedef struct packed {
      logic                      write;
      logic [DefAddrWidth-1:0]   addr;
      amo_op_e                   amo;
      logic [DefDataWidth-1:0]   data;
      logic [DefDataWidth/8-1:0] strb;
      logic [0:0]                user;
   } tcdm_req_chan_t;

   typedef struct packed {
      tcdm_req_chan_t q;
      logic           q_valid;
   } tcdm_req_default_t;

   typedef struct packed {
      logic [DefDataWidth-1:0] data;
   } tcdm_rsp_chan_t;

   typedef struct packed {
      tcdm_rsp_chan_t p;
      logic           p_valid;
      logic           q_ready;
   } tcdm_rsp_default_t;

endpackage

// File: rtl/snax_tcdm_rr_token.sv
// Rotating one-hot grant token.
// - clk_i  : clock
// - rst_ni : asynchronous active-low reset; token returns to bit 0
// - tok_o  : one-hot token, advances one position per cycle, N-1 wraps to 0
module snax_tcdm_rr_token #(
   parameter int unsigned N = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   output logic [N-1:0] tok_o
);

   logic [N-1:0] tok_d, tok_q;

   always_comb begin
      tok_d = (tok_q << 1) | (tok_q >> (N - 1));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tok_q <= N'(1);
      end else begin
         tok_q <= tok_d;
      end
   end

   assign tok_o = tok_q;

endmodule

// File: rtl/snax_tcdm_responder.sv
// Single-bank TCDM responder: grants one initiator port per cycle by rotating
// token, performs byte-strobed writes or 1-cycle-latency reads on a word array.
// - clk_i, rst_ni : clock, asynchronous active-low reset
// - tcdm_req_i    : per-port requests (q, q_valid)
// - tcdm_rsp_o    : per-port responses (q_ready, p_valid, p.data)
// - stall_cnt_o   : saturating count of cycles with at least one denied request
module snax_tcdm_responder
   import snax_tcdm_pkg::*;
#(
   parameter int unsigned SnaxTcdmPorts = 4,
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned TCDMAddrWidth = 48,
   parameter int unsigned Depth         = 64,
   parameter int unsigned AddrLsb       = 0,
   parameter type         tcdm_req_t    = tcdm_req_default_t,
   parameter type         tcdm_rsp_t    = tcdm_rsp_default_t
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  tcdm_req_t [SnaxTcdmPorts-1:0] tcdm_req_i,
   output tcdm_rsp_t [SnaxTcdmPorts-1:0] tcdm_rsp_o,
   output logic [31:0]                   stall_cnt_o
);

   localparam int unsigned IdxW  = $clog2(Depth);
   localparam int unsigned PortW = (SnaxTcdmPorts > 1) ? $clog2(SnaxTcdmPorts) : 1;
   localparam int unsigned StrbW = DataWidth / 8;

   typedef struct packed {
      logic [PortW-1:0]     port;
      logic                 valid;
      logic [DataWidth-1:0] data;
   } rsp_reg_t;

   logic [SnaxTcdmPorts-1:0] tok, valid_vec, gnt;
   logic                     hs, stall_any;
   logic                     sel_write;
   logic [IdxW-1:0]          sel_idx;
   logic [DataWidth-1:0]     sel_data;
   logic [StrbW-1:0]         sel_strb;
   logic [PortW-1:0]         sel_port;

   logic [DataWidth-1:0] mem_d [Depth];
   logic [DataWidth-1:0] mem_q [Depth];
   rsp_reg_t             rsp_d, rsp_q;
   logic [31:0]          stall_cnt_d, stall_cnt_q;

   // amo, user and upper address bits carry no meaning here.
   logic unused_req;
   assign unused_req = ^tcdm_req_i;

   snax_tcdm_rr_token #(
      .N (SnaxTcdmPorts)
   ) u_token (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tok_o  (tok)
   );

   // Token is one-hot, so at most one grant bit can be set.
   always_comb begin
      valid_vec = '0;
      sel_write = 1'b0;
      sel_idx   = '0;
      sel_data  = '0;
      sel_strb  = '0;
      sel_port  = '0;
      for (int i = 0; i < SnaxTcdmPorts; i++) begin
         valid_vec[i] = tcdm_req_i[i].q_valid;
      end
      gnt       = valid_vec & tok;
      hs        = |gnt;
      stall_any = |(valid_vec & ~tok);
      for (int i = 0; i < SnaxTcdmPorts; i++) begin
         if (gnt[i]) begin
            sel_write = tcdm_req_i[i].q.write;
            sel_idx   = tcdm_req_i[i].q.addr[AddrLsb +: IdxW];
            sel_data  = tcdm_req_i[i].q.data;
            sel_strb  = tcdm_req_i[i].q.strb;
            sel_port  = PortW'(i);
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (hs && sel_write) begin
         for (int b = 0; b < StrbW; b++) begin
            if (sel_strb[b]) begin
               mem_d[sel_idx][8*b +: 8] = sel_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rsp_d.valid = hs && !sel_write;
      rsp_d.port  = sel_port;
      rsp_d.data  = rsp_d.valid ? mem_q[sel_idx] : '0;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_any && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q       <= '{default: '0};
         rsp_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         mem_q       <= mem_d;
         rsp_q       <= rsp_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // q_ready comes straight from the token register: no path from q_valid.
   always_comb begin
      for (int i = 0; i < SnaxTcdmPorts; i++) begin
         tcdm_rsp_o[i]         = '0;
         tcdm_rsp_o[i].q_ready = tok[i];
         if (rsp_q.valid && (rsp_q.port == PortW'(i))) begin
            tcdm_rsp_o[i].p_valid = 1'b1;
            tcdm_rsp_o[i].p.data  = rsp_q.data;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_snax_tcdm_responder.sv
module tb_snax_tcdm_responder;
   import snax_tcdm_pkg::*;

   logic                         clk;
   logic                         rst_n;
   tcdm_req_default_t [3:0]      req;
   tcdm_rsp_default_t [3:0]      rsp;
   logic [31:0]                  stall_cnt;

   int checks = 0;
   int errors = 0;

   snax_tcdm_responder #(
      .SnaxTcdmPorts (4),
      .DataWidth     (64),
      .TCDMAddrWidth (48),
      .Depth         (64),
      .AddrLsb       (0),
      .tcdm_req_t    (tcdm_req_default_t),
      .tcdm_rsp_t    (tcdm_rsp_default_t)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .tcdm_req_i  (req),
      .tcdm_rsp_o  (rsp),
      .stall_cnt_o (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          port;
      logic        write;
      logic [47:0] addr;
      amo_op_e     amo;
      logic [63:0] data;
      logic [7:0]  strb;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] ready_vec();
      logic [3:0] r;
      for (int j = 0; j < 4; j++) r[j] = rsp[j].q_ready;
      return r;
   endfunction

   // Reset asserted now, released on a falling edge.
   task automatic apply_reset();
      req   = '0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Waits (at falling edges) for the port's slot; returns with ok=0 on timeout.
   task automatic wait_slot(input int port, output bit ok);
      ok = 1'b0;
      for (int w = 0; w < 8; w++) begin
         @(negedge clk);
         if (rsp[port].q_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("slot_timeout", 64'd0, 64'd1);
   endtask

   // One request at the port's slot; returns just after the handshake edge.
   task automatic do_req(input int port, input logic write, input logic [47:0] addr,
                         input amo_op_e amo, input logic [63:0] data, input logic [7:0] strb);
      bit ok;
      wait_slot(port, ok);
      req[port].q.write = write;
      req[port].q.addr  = addr;
      req[port].q.amo   = amo;
      req[port].q.data  = data;
      req[port].q.strb  = strb;
      req[port].q_valid = 1'b1;
      @(posedge clk);
      #1;
      req[port] = '0;
   endtask

   task automatic chk_rsp(input string name, input int port, input logic exp_valid,
                          input logic [63:0] exp_data);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("%s_pvalid%0d", name, j), 64'(rsp[j].p_valid),
             64'((j == port) && exp_valid));
         chk($sformatf("%s_pdata%0d", name, j), rsp[j].p.data,
             ((j == port) && exp_valid) ? exp_data : 64'd0);
      end
   endtask

   initial begin
      bit ok;
      logic [3:0] exp_rdy;
      int hs_cnt;

      vecs[0] = '{0, 1'b1, 48'd5,  AMONone, 64'h1122_3344_5566_7788, 8'hFF, 64'd0};
      vecs[1] = '{1, 1'b0, 48'd5,  AMONone, 64'd0, 8'h00, 64'h1122_3344_5566_7788};
      vecs[2] = '{2, 1'b1, 48'd9,  AMONone, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0};
      vecs[3] = '{3, 1'b0, 48'd9,  AMONone, 64'd0, 8'h00, 64'h0000_0000_FFFF_FFFF};
      vecs[4] = '{0, 1'b1, 48'd70, AMONone, 64'hA5, 8'hFF, 64'd0};
      vecs[5] = '{1, 1'b0, 48'd6,  AMONone, 64'd0, 8'h00, 64'hA5};
      vecs[6] = '{2, 1'b1, 48'd5,  AMOAdd,  64'hDEAD_BEEF_0000_0000, 8'hF0, 64'd0};
      vecs[7] = '{3, 1'b0, 48'd5,  AMONone, 64'd0, 8'h00, 64'hDEAD_BEEF_5566_7788};
      vecs[8] = '{0, 1'b0, 48'hFFFF_FFFF_FFC5, AMOSwap, 64'd0, 8'h00, 64'hDEAD_BEEF_5566_7788};
      vecs[9] = '{1, 1'b0, 48'd10, AMONone, 64'd0, 8'h00, 64'd0};

      // Reset then idle: token walks 0001,0010,0100,1000,0001.
      apply_reset();
      #1;
      exp_rdy = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("idle_ready%0d", c), 64'(ready_vec()), 64'(exp_rdy));
         chk($sformatf("idle_pvalid%0d", c),
             64'({rsp[3].p_valid, rsp[2].p_valid, rsp[1].p_valid, rsp[0].p_valid}), 64'd0);
         exp_rdy = {exp_rdy[2:0], exp_rdy[3]};
      end
      chk("idle_stall", 64'(stall_cnt), 64'd0);

      // Table-driven single accesses.
      for (int v = 0; v < 10; v++) begin
         do_req(vecs[v].port, vecs[v].write, vecs[v].addr, vecs[v].amo,
                vecs[v].data, vecs[v].strb);
         @(negedge clk);
         chk_rsp($sformatf("vec%0d", v), vecs[v].port, !vecs[v].write, vecs[v].exp);
         @(negedge clk);
         chk_rsp($sformatf("vec%0d_after", v), vecs[v].port, 1'b0, 64'd0);
      end

      // Write in one cycle, read of the same word handshaked the very next cycle.
      wait_slot(0, ok);
      req[0].q.write = 1'b1;
      req[0].q.addr  = 48'd20;
      req[0].q.data  = 64'h0BAD_F00D_1234_5678;
      req[0].q.strb  = 8'hFF;
      req[0].q_valid = 1'b1;
      @(negedge clk);
      req[0] = '0;
      req[1].q.addr  = 48'd20;
      req[1].q_valid = 1'b1;
      @(negedge clk);
      req[1] = '0;
      chk_rsp("b2b", 1, 1'b1, 64'h0BAD_F00D_1234_5678);
      chk("b2b_stall", 64'(stall_cnt), 64'd0);

      // Reset while a read response is pending.
      do_req(2, 1'b1, 48'd12, AMONone, 64'hCAFE_0000_0000_BABE, 8'hFF);
      wait_slot(3, ok);
      req[3].q.addr  = 48'd12;
      req[3].q_valid = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_rsp("rst_drop", 3, 1'b0, 64'd0);
      chk("rst_ready", 64'(ready_vec()), 64'b0001);
      chk("rst_stall", 64'(stall_cnt), 64'd0);
      do_req(1, 1'b0, 48'd12, AMONone, 64'd0, 8'h00);
      @(negedge clk);
      chk_rsp("rst_zero12", 1, 1'b1, 64'd0);
      do_req(2, 1'b0, 48'd5, AMONone, 64'd0, 8'h00);
      @(negedge clk);
      chk_rsp("rst_zero5", 2, 1'b1, 64'd0);

      // All ports request continuously for 8 cycles.
      apply_reset();
      for (int j = 0; j < 4; j++) begin
         req[j].q.addr  = 48'(j);
         req[j].q_valid = 1'b1;
      end
      hs_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk_rsp($sformatf("sat%0d", k), k % 4, 1'b1, 64'd0);
         for (int j = 0; j < 4; j++) if (rsp[j].p_valid) hs_cnt++;
         if (k == 7) req = '0;
      end
      chk("sat_stall", 64'(stall_cnt), 64'd8);
      @(negedge clk);
      chk_rsp("sat_tail", 0, 1'b0, 64'd0);
      chk("sat_handshakes", 64'(hs_cnt), 64'd8);
      chk("sat_stall_hold", 64'(stall_cnt), 64'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
